// File: rtl/async_reset_seq_pkg.sv
// Shared types, constants and elaboration helpers for the async reset sequencer.
// Included by the top and the down-counter sub-module.
package async_reset_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } seq_state_e;

    // Flat constants so the state register can stay a plain logic vector
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_HOLD    = HOLD;
    localparam logic [1:0] ST_RELEASE = RELEASE;
    localparam logic [1:0] ST_DONE    = DONE;

    localparam int N_OUT_DFLT = 4;
    localparam int IDX_W      = $clog2(N_OUT_DFLT);

    // Index width for an arbitrary output count; a single output still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit cnt_fits(input int cnt_w, input int hold, input int stag);
        longint lim;
        lim = (longint'(1) << cnt_w) - 1;
        return (hold >= 1) && (stag >= 0) && (longint'(hold) <= lim) && (longint'(stag) <= lim);
    endfunction

endpackage

// File: rtl/reset_down_counter.sv
// Loadable down counter with a zero flag; it times both the hold window and the
// per-bit stagger gap, and saturates at zero instead of wrapping.
module reset_down_counter
    import async_reset_seq_pkg::*;
#(
    parameter int              CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/async_reset_sequencer.sv
// Produces registered reset outputs from a synchronous request: assert the masked
// bits, hold them, then release them in index order with a fixed gap after each.
module async_reset_sequencer
    import async_reset_seq_pkg::*;
#(
    parameter int N_OUT       = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int STAGGER     = 2,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N_OUT-1:0] req_mask,
    output logic [N_OUT-1:0] rst_out,
    output logic             busy,
    output logic             done
);

    localparam int               SEL_W   = idx_width(N_OUT);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LD = (STAGGER > 0) ? CNT_W'(STAGGER - 1) : '0;
    localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(N_OUT - 1);

    generate
        if (!cnt_fits(CNT_W, HOLD_CYCLES, STAGGER)) begin : g_cnt_w_check
            $error("async_reset_sequencer: CNT_W cannot hold HOLD_CYCLES/STAGGER");
        end
    endgenerate

    logic [1:0]       state;
    logic [N_OUT-1:0] mask;
    logic [SEL_W-1:0] idx;
    logic             stag_wait;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             accept;
    logic             last_idx;
    logic             clr_now;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = req_ready && req_valid;
    assign last_idx  = (idx == IDX_MAX);
    // A masked bit is cleared on the first RELEASE cycle spent at its index
    assign clr_now   = (state == ST_RELEASE) && !stag_wait && mask[idx];

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = HOLD_LD;
        cnt_dec  = 1'b0;
        if (accept && (req_mask != '0)) begin
            cnt_load = 1'b1;
            cnt_val  = HOLD_LD;
        end else if (clr_now && (STAGGER > 0)) begin
            cnt_load = 1'b1;
            cnt_val  = STAG_LD;
        end else if ((state == ST_HOLD) || ((state == ST_RELEASE) && stag_wait)) begin
            cnt_dec  = 1'b1;
        end
    end

    reset_down_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (HOLD_LD)
    ) u_cnt (
        .clk      (CLK),
        .reset    (RESET),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_HOLD;
            rst_out   <= '1;
            mask      <= '1;
            idx       <= '0;
            stag_wait <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_mask != '0) begin
                            mask    <= req_mask;
                            rst_out <= rst_out | req_mask;
                            state   <= ST_HOLD;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        state     <= ST_RELEASE;
                        idx       <= '0;
                        stag_wait <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    if (clr_now) begin
                        rst_out[idx] <= 1'b0;
                    end
                    // Advance when the gap has elapsed, or immediately if no gap is owed
                    if ((stag_wait && cnt_zero) || (!stag_wait && !(mask[idx] && (STAGGER > 0)))) begin
                        stag_wait <= 1'b0;
                        if (last_idx) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + SEL_W'(1);
                        end
                    end else if (clr_now) begin
                        stag_wait <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_async_reset_sequencer.sv
// Directed bench: default 4-output instance for the request scenarios, plus an
// 8-output zero-stagger instance for back-to-back release and glitch counting.
module tb_async_reset_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RESET, req_valid, req_ready, busy, done;
    logic [3:0] req_mask, rst_out;

    logic       RESET_b, req_valid_b, req_ready_b, busy_b, done_b;
    logic [7:0] req_mask_b, rst_out_b;

    int n_cmp = 0;
    int n_bad = 0;

    async_reset_sequencer #(.N_OUT(4), .HOLD_CYCLES(8), .STAGGER(2), .CNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_mask(req_mask), .rst_out(rst_out), .busy(busy), .done(done));

    async_reset_sequencer #(.N_OUT(8), .HOLD_CYCLES(8), .STAGGER(0), .CNT_W(8)) dut_b (
        .CLK(CLK), .RESET(RESET_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_mask(req_mask_b), .rst_out(rst_out_b), .busy(busy_b), .done(done_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Glitch monitor on the 8-output instance
    logic [7:0] prev_b = 8'h00;
    int         falls[8] = '{default: 0};
    int         rises = 0;
    bit         mon_en = 1'b0;
    always @(negedge CLK) begin
        if (mon_en) begin
            for (int i = 0; i < 8; i++) begin
                if (prev_b[i] && !rst_out_b[i]) falls[i]++;
                if (!prev_b[i] && rst_out_b[i]) rises++;
            end
        end
        prev_b = rst_out_b;
    end

    // Checks cycles 1..last_c after edge 0 (the accept or last reset edge).
    // Bit i of m clears 9 + (cycles used by lower indices) edges later; each masked
    // index costs 1+STAGGER=3 cycles, each unmasked one 1 cycle.
    task automatic seq_check(input string tag, input logic [3:0] m, input logic [3:0] base,
                             input int last_c, output int obs_done, output int pulses);
        int clr[4];
        int t;
        int done_c;
        logic [3:0] e;
        t = 9;
        for (int i = 0; i < 4; i++) begin
            clr[i] = 1 << 30;
            if (m[i]) begin clr[i] = t; t += 3; end
            else t += 1;
        end
        done_c   = t - 1;
        obs_done = -1;
        pulses   = 0;
        for (int c = 1; c <= last_c; c++) begin
            step();
            e = base | m;
            for (int i = 0; i < 4; i++) if (m[i] && c >= clr[i]) e[i] = 1'b0;
            chk({tag, "/rst_out"}, 32'(rst_out), 32'(e));
            chk({tag, "/done"}, 32'(done), 32'(c == done_c));
            chk({tag, "/busy"}, 32'(busy), 32'(c <= done_c));
            chk({tag, "/req_ready"}, 32'(req_ready), 32'(c > done_c));
            if (done === 1'b1) begin
                pulses++;
                if (obs_done < 0) obs_done = c;
            end
        end
    endtask

    int od, np;

    initial begin
        RESET = 1'b1; req_valid = 1'b0; req_mask = 4'h0;
        RESET_b = 1'b1; req_valid_b = 1'b0; req_mask_b = 8'h00;

        // 1: power-on release
        repeat (3) step();
        chk("rst/rst_out", 32'(rst_out), 32'hF);
        chk("rst/busy", 32'(busy), 32'd1);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/req_ready", 32'(req_ready), 32'd0);
        RESET = 1'b0;
        seq_check("por", 4'hF, 4'h0, 21, od, np);
        chk("por/latency", 32'(od + 1), 32'd21);
        chk("por/pulses", 32'(np), 32'd1);

        // 2: mask 0101 from IDLE
        req_valid = 1'b1; req_mask = 4'b0101;
        chk("m5/ready_pre", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0; req_mask = 4'h0;
        chk("m5/assert", 32'(rst_out), 32'h5);
        seq_check("m5", 4'b0101, 4'h0, 17, od, np);
        chk("m5/latency", 32'(od + 1), 32'd17);
        chk("m5/pulses", 32'(np), 32'd1);

        // 3: empty mask goes straight to DONE
        req_valid = 1'b1; req_mask = 4'h0;
        chk("m0/ready_pre", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("m0/done", 32'(done), 32'd1);
        chk("m0/busy", 32'(busy), 32'd1);
        chk("m0/rst_out", 32'(rst_out), 32'h0);
        step();
        chk("m0/done_after", 32'(done), 32'd0);
        chk("m0/busy_after", 32'(busy), 32'd0);
        chk("m0/rst_out_after", 32'(rst_out), 32'h0);

        // 4: req_valid held during a sequence; the second request must be dropped
        req_valid = 1'b1; req_mask = 4'b1000;
        step();
        req_mask = 4'b0001;
        chk("busyreq/assert", 32'(rst_out), 32'h8);
        seq_check("busyreq", 4'b1000, 4'h0, 15, od, np);
        req_valid = 1'b0; req_mask = 4'h0;
        chk("busyreq/latency", 32'(od + 1), 32'd15);
        chk("busyreq/pulses", 32'(np), 32'd1);
        step();
        chk("busyreq/idle_busy", 32'(busy), 32'd0);
        chk("busyreq/idle_rst", 32'(rst_out), 32'h0);

        // 5: RESET while releasing
        req_valid = 1'b1; req_mask = 4'hF;
        step();
        req_valid = 1'b0; req_mask = 4'h0;
        seq_check("pre_rst", 4'hF, 4'h0, 10, od, np);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("midrst/rst_out", 32'(rst_out), 32'hF);
        chk("midrst/busy", 32'(busy), 32'd1);
        chk("midrst/done", 32'(done), 32'd0);
        seq_check("rerun", 4'hF, 4'hF, 21, od, np);
        chk("rerun/latency", 32'(od + 1), 32'd21);
        chk("rerun/pulses", 32'(np), 32'd1);

        // 6: eight outputs, zero stagger, released on consecutive cycles
        chk("b/rst_out_rst", 32'(rst_out_b), 32'hFF);
        mon_en = 1'b1;
        RESET_b = 1'b0;
        od = -1;
        for (int c = 1; c <= 17; c++) begin
            logic [7:0] e;
            step();
            e = 8'hFF;
            for (int i = 0; i < 8; i++) if (c >= 9 + i) e[i] = 1'b0;
            chk("b/rst_out", 32'(rst_out_b), 32'(e));
            chk("b/done", 32'(done_b), 32'(c == 16));
            if (done_b === 1'b1 && od < 0) od = c;
        end
        chk("b/latency", 32'(od + 1), 32'd17);
        chk("b/busy_end", 32'(busy_b), 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("b/falls%0d", i), 32'(falls[i]), 32'd1);
        chk("b/rises", 32'(rises), 32'd0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
